fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage sitting directly upstream of the controller. Holds the program counter and instruction register, runs a req/ack fetch handshake against instruction memory, and presents the fetched byte as `Opcode` to the controller. Consumes the controller's `LoadIR`, `IncPC`, `SelPC` and `LoadPC` strobes. Latches a halted state when a HALT opcode is fetched.

## Interface
- `PC_W`, default 8: program counter and memory address width.
- `INSTR_W`, default 8: instruction width; the opcode field is the top 4 bits.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `LoadIR`  in  1  controller strobe to start a fetch at the current PC.
- `IncPC`  in  1  PC <= PC + 1.
- `LoadPC`  in  1  PC <= jump target.
- `SelPC`  in  1  jump target select: 0 = `RegData`, 1 = zero-extended `Opcode[3:0]`.
- `RegData`  in  PC_W  register-file value used as the register jump target.
- `imem_req`  out  1  fetch request, held until acknowledged.
- `imem_addr`  out  PC_W  fetch address, stable while `imem_req` is high.
- `imem_ack`  in  1  memory has placed the instruction on `imem_data`.
- `imem_data`  in  INSTR_W  instruction byte.
- `Opcode`  out  INSTR_W  instruction register contents.
- `IRValid`  out  1  `Opcode` holds a freshly fetched instruction.
- `Halted`  out  1  a HALT instruction has been fetched.
- `PC`  out  PC_W  current program counter.

## Operation
- Reset values: PC = 0, `Opcode` = 0 (NOP), `IRValid` = 0, `imem_req` = 0, `imem_addr` = 0, `Halted` = 0, state = IDLE.
- **IDLE**
  - `LoadIR` = 1: `imem_addr` <= PC, `imem_req` <= 1, `IRValid` <= 0, go to WAIT.
- **WAIT**
  - `imem_req` and `imem_addr` are held.
  - `LoadIR` is ignored.
  - On `imem_ack` = 1: `Opcode` <= `imem_data`, `IRValid` <= 1, `imem_req` <= 0.
  - If `imem_data[7:4]` = 4'hF: go to HALT and set `Halted` <= 1. Otherwise go to IDLE.
- **HALT**
  - Terminal until reset.
  - `LoadIR`, `IncPC` and `LoadPC` are all ignored; PC is frozen; `IRValid` stays 1.
- **PC update** (IDLE and WAIT)
  - `LoadPC` has priority over `IncPC`.
  - The target uses the `Opcode[3:0]` value current in that cycle, i.e. before any same-edge IR load.
  - PC arithmetic is modulo 2^PC_W; all-ones + 1 wraps to 0.
  - `imem_addr` is a separate register, so a PC change during WAIT never alters an outstanding request.
- **Stray ack**: `imem_ack` with `imem_req` low is ignored.

## Timing
- `LoadIR` sampled at edge N gives `imem_req` = 1 from N+1.
- `imem_ack` sampled high at edge M gives `Opcode`/`IRValid` updated and `imem_req` low from M+1.
- Zero-wait memory (ack in the first request cycle): `Opcode` is valid 2 edges after `LoadIR`.
- `Halted` rises on the same edge that loads the HALT opcode into `Opcode`.
- Reset during WAIT: `imem_req` is low from the next edge. Any ack arriving afterwards is ignored.
- Reset during HALT clears the halt.
- A new request is accepted at the earliest on the edge after an ack, once back in IDLE. There is no back-to-back overlap.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants `OP_NOP` = 4'h0 and `OP_HALT` = 4'hF, shared with the controller;
  - the fetch state enum {IDLE, WAIT, HALT}.
- One natural sub-module, `pc_reg`: PC register with load/increment priority and the target mux.
- The FSM, IR and memory interface stay in `fetch_unit`.

## Test plan
- **Reset, then a zero-wait fetch.** Stimulus: reset, then `LoadIR` with memory acking the first request cycle, `mem[0]` = 8'h43. Expect:
  - `imem_addr` = 0;
  - `Opcode` = 8'h43 and `IRValid` = 1 two edges after `LoadIR`;
  - then `IncPC` drives PC to 1.
- **Wait states with a PC change mid-request.** Stimulus: ack delayed 3 cycles, `IncPC` pulsed during WAIT. Expect:
  - `imem_req` held high for 3 cycles;
  - `imem_addr` unchanged throughout;
  - PC incremented once.
- **Jump targets.** Stimulus: `Opcode` = 8'h7A with `LoadPC` = `SelPC` = 1, then `LoadPC` = 1 with `SelPC` = 0 and `RegData` = 8'h3C. Expect PC = 8'h0A, then PC = 8'h3C. With `LoadPC` and `IncPC` asserted together, expect the load to win.
- **Wrap-around.** Stimulus: PC = 8'hFF, `IncPC`. Expect PC = 8'h00.
- **Halt.** Stimulus: fetch 8'hF0, then pulse `LoadIR`, `IncPC` and `LoadPC`. Expect:
  - `Halted` = 1;
  - no further `imem_req`;
  - PC frozen;
  - after reset, `Halted` = 0 and PC = 0.
- **Reset mid-fetch.** Stimulus: reset while in WAIT, then a late ack. Expect:
  - `imem_req` = 0 after reset;
  - `Opcode` = 0 and `IRValid` = 0 after reset;
  - the late ack has no effect.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode field constants and the fetch-stage state encoding.
package cpu_pkg;

   localparam int unsigned OPC_W = 4;

   localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
   localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   // True when the opcode field of an instruction is the HALT encoding.
   function automatic logic is_halt(input logic [OPC_W-1:0] op);
      return op == OP_HALT;
   endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: jump-target mux plus load/increment with load taking priority.
module pc_reg
   import cpu_pkg::*;
#(
   parameter int unsigned PC_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hold,
   input  logic             load,
   input  logic             inc,
   input  logic             sel,
   input  logic [PC_W-1:0]  reg_data,
   input  logic [OPC_W-1:0] imm,
   output logic [PC_W-1:0]  pc
);

   logic [PC_W-1:0] target_c;

   // sel = 1 jumps to the zero-extended immediate, otherwise to the register value
   always_comb begin
      target_c = reg_data;
      if (sel) begin
         target_c = PC_W'(imm);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= '0;
      end else if (!hold) begin
         if (load) begin
            pc <= target_c;
         end else if (inc) begin
            pc <= pc + PC_W'(1);
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, instruction register, and req/ack handshake to instruction memory.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned PC_W    = 8,
   parameter int unsigned INSTR_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               LoadIR,
   input  logic               IncPC,
   input  logic               LoadPC,
   input  logic               SelPC,
   input  logic [PC_W-1:0]    RegData,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [INSTR_W-1:0] Opcode,
   output logic               IRValid,
   output logic               Halted,
   output logic [PC_W-1:0]    PC
);

   fetch_state_t state;

   // PC freezes once halted; jump immediate is taken from the IR before any same-edge load
   pc_reg #(
      .PC_W (PC_W)
   ) u_pc_reg (
      .clk      (clk),
      .reset    (reset),
      .hold     (state == HALT),
      .load     (LoadPC),
      .inc      (IncPC),
      .sel      (SelPC),
      .reg_data (RegData),
      .imm      (Opcode[OPC_W-1:0]),
      .pc       (PC)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         Opcode    <= INSTR_W'(OP_NOP);
         IRValid   <= 1'b0;
         imem_req  <= 1'b0;
         imem_addr <= '0;
         Halted    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (LoadIR) begin
                  imem_addr <= PC;
                  imem_req  <= 1'b1;
                  IRValid   <= 1'b0;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (imem_ack) begin
                  Opcode   <= imem_data;
                  IRValid  <= 1'b1;
                  imem_req <= 1'b0;
                  if (is_halt(imem_data[INSTR_W-1 -: OPC_W])) begin
                     Halted <= 1'b1;
                     state  <= HALT;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit against a transaction-level model.
module tb_fetch_unit;

   logic       clk;
   logic       reset;
   logic       LoadIR, IncPC, LoadPC, SelPC;
   logic [7:0] RegData;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic       imem_ack;
   logic [7:0] imem_data;
   logic [7:0] Opcode;
   logic       IRValid;
   logic       Halted;
   logic [7:0] PC;

   int total = 0;
   int bad   = 0;

   logic [7:0] mem [256];

   // reference model state
   logic [7:0] m_pc, m_ir, m_data;
   logic       m_irv, m_req, m_halted;
   logic [7:0] req_q[$];
   logic [7:0] fetch_q[$];

   // memory responder controls
   int   fixed_delay = 0;
   bit   stray_en    = 0;
   bit   force_ack   = 0;
   bit   in_req      = 0;
   int   cnt         = 0;
   int   tgt         = 0;

   fetch_unit #(.PC_W(8), .INSTR_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .LoadIR    (LoadIR),
      .IncPC     (IncPC),
      .LoadPC    (LoadPC),
      .SelPC     (SelPC),
      .RegData   (RegData),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_ack  (imem_ack),
      .imem_data (imem_data),
      .Opcode    (Opcode),
      .IRValid   (IRValid),
      .Halted    (Halted),
      .PC        (PC)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: applies the fetch rules at each rising edge using the driven inputs.
   initial begin
      logic [3:0] old_lo;
      forever begin
         @(posedge clk);
         if (reset) begin
            m_pc = 8'h00; m_ir = 8'h00; m_irv = 1'b0; m_req = 1'b0; m_halted = 1'b0;
            fetch_q.delete();
            req_q.delete();
         end else if (!m_halted) begin
            old_lo = m_ir[3:0];
            if (m_req) begin
               if (imem_ack) begin
                  m_ir  = m_data;
                  m_irv = 1'b1;
                  m_req = 1'b0;
                  if (m_ir[7:4] == 4'hF) m_halted = 1'b1;
               end
            end else if (LoadIR) begin
               m_req  = 1'b1;
               m_irv  = 1'b0;
               m_data = mem[m_pc];
               req_q.push_back(m_pc);
               fetch_q.push_back(mem[m_pc]);
            end
            if (LoadPC)     m_pc = SelPC ? {4'h0, old_lo} : RegData;
            else if (IncPC) m_pc = m_pc + 8'd1;
         end
      end
   end

   // Monitor: per-cycle state checks plus scoreboard pops on new requests and new instructions.
   initial begin
      logic       prev_req;
      logic       prev_irv;
      logic [7:0] cur_addr;
      prev_req = 1'b0;
      prev_irv = 1'b0;
      cur_addr = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         check("pc", PC, m_pc);
         check("halted", Halted, m_halted);
         check("imem_req", imem_req, m_req);
         check("irvalid", IRValid, m_irv);
         check("ir", Opcode, m_ir);
         if (imem_req && !prev_req) begin
            if (req_q.size() == 0) check("req_unexpected", 1, 0);
            else cur_addr = req_q.pop_front();
         end
         if (imem_req) check("imem_addr", imem_addr, cur_addr);
         if (IRValid && !prev_irv) begin
            if (fetch_q.size() == 0) check("fetch_unexpected", 1, 0);
            else check("opcode", Opcode, fetch_q.pop_front());
         end
         prev_req = imem_req;
         prev_irv = IRValid;
      end
   end

   // Drive memory response for this cycle, then advance one clock (ends on a falling edge).
   task automatic tick();
      if (force_ack) begin
         imem_ack  = 1'b1;
         imem_data = 8'h99;
         force_ack = 0;
      end else if (imem_req) begin
         if (!in_req) begin
            in_req = 1;
            cnt    = 0;
            tgt    = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
         end
         if (cnt == tgt) begin
            imem_ack  = 1'b1;
            imem_data = mem[imem_addr];
         end else begin
            imem_ack  = 1'b0;
            imem_data = 8'($urandom);
         end
         cnt++;
      end else begin
         in_req = 0;
         if (stray_en && $urandom_range(0, 3) == 0) begin
            imem_ack  = 1'b1;
            imem_data = 8'($urandom);
         end else begin
            imem_ack = 1'b0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 239));
      reset = 1'b1; LoadIR = 0; IncPC = 0; LoadPC = 0; SelPC = 0;
      RegData = 8'h00; imem_ack = 0; imem_data = 8'h00;
      m_pc = 0; m_ir = 0; m_data = 0; m_irv = 0; m_req = 0; m_halted = 0;
      tick(); tick();
      reset = 1'b0;
      check("rst_pc", PC, 8'h00);
      check("rst_opcode", Opcode, 8'h00);

      // zero-wait fetch of 0x43
      mem[0] = 8'h43; fixed_delay = 0;
      LoadIR = 1; tick(); LoadIR = 0;
      check("zw_addr", imem_addr, 8'h00);
      check("zw_req", imem_req, 1);
      tick();
      check("zw_opcode", Opcode, 8'h43);
      check("zw_irvalid", IRValid, 1);
      IncPC = 1; tick(); IncPC = 0;
      check("zw_inc", PC, 8'h01);

      // wait states with an increment during the request
      fixed_delay = 3;
      LoadIR = 1; tick(); LoadIR = 0;
      IncPC = 1; tick(); IncPC = 0;
      repeat (4) tick();
      check("ws_pc", PC, 8'h02);
      check("ws_done", IRValid, 1);

      // jump targets
      mem[2] = 8'h7A; fixed_delay = 0;
      LoadIR = 1; tick(); LoadIR = 0; tick();
      check("jmp_opcode", Opcode, 8'h7A);
      LoadPC = 1; SelPC = 1; tick();
      check("jmp_imm", PC, 8'h0A);
      SelPC = 0; RegData = 8'h3C; tick();
      check("jmp_reg", PC, 8'h3C);
      IncPC = 1; RegData = 8'h55; tick();
      check("jmp_prio", PC, 8'h55);
      IncPC = 0;

      // wrap-around
      RegData = 8'hFF; tick();
      LoadPC = 0; IncPC = 1; tick(); IncPC = 0;
      check("wrap", PC, 8'h00);

      // randomised traffic with stray acks and occasional reset
      stray_en = 1; fixed_delay = -1;
      for (int n = 0; n < 2000; n++) begin
         reset   = ($urandom_range(0, 149) == 0);
         LoadIR  = 1'($urandom_range(0, 1));
         IncPC   = ($urandom_range(0, 3) == 0);
         LoadPC  = ($urandom_range(0, 7) == 0);
         SelPC   = 1'($urandom_range(0, 1));
         RegData = 8'($urandom);
         tick();
      end
      reset = 0; LoadIR = 0; IncPC = 0; LoadPC = 0; stray_en = 0;

      // halt: fetch 0xF0 with an increment during the request, then try to disturb it
      reset = 1; tick(); reset = 0;
      mem[0] = 8'hF0; fixed_delay = 1;
      LoadIR = 1; tick(); LoadIR = 0;
      IncPC = 1; tick(); IncPC = 0;
      tick();
      check("halt_set", Halted, 1);
      check("halt_opcode", Opcode, 8'hF0);
      LoadIR = 1; IncPC = 1; LoadPC = 1; SelPC = 0; RegData = 8'h77;
      repeat (3) tick();
      LoadIR = 0; IncPC = 0; LoadPC = 0;
      check("halt_pc", PC, 8'h01);
      check("halt_noreq", imem_req, 0);
      check("halt_irv", IRValid, 1);
      reset = 1; tick(); reset = 0;
      check("halt_clr", Halted, 0);
      check("halt_pc0", PC, 8'h00);

      // reset while waiting, then a late ack
      fixed_delay = 10;
      LoadIR = 1; tick(); LoadIR = 0; tick();
      check("mid_req", imem_req, 1);
      reset = 1; tick(); reset = 0;
      check("mid_req0", imem_req, 0);
      check("mid_op0", Opcode, 8'h00);
      check("mid_irv0", IRValid, 0);
      force_ack = 1; tick(); tick();
      check("late_op", Opcode, 8'h00);
      check("late_irv", IRValid, 0);
      check("late_req", imem_req, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
